regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined CPU: N combinational read ports and two write ports.
  - Port A is the ALU/EX writeback.
  - Port B is the memory/load writeback.
- Write-to-read bypass on both write ports.
- Per-register busy scoreboard: tracks outstanding load destinations so decode can detect RAW/WAW hazards. Replaces the single-write, two-read file.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- DBG_IDX, 28, index of the register exported on dbg_data.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  read register has an outstanding load.
- wa_en, wa_addr, wa_data  in  1, ADDR_W, DATA_W  write port A (ALU).
- wb_en, wb_addr, wb_data  in  1, ADDR_W, DATA_W  write port B (load); also clears busy.
- iss_valid  in  1  load issued this cycle.
- iss_addr  in  ADDR_W  load destination to mark busy.
- iss_stall  out  1  issue refused: WAW on a busy register.
- pending_cnt  out  ADDR_W+1  number of busy registers.
- wr_conflict  out  1  registered pulse: A and B wrote the same nonzero address last cycle.
- dbg_data  out  DATA_W  contents of register DBG_IDX.

Behaviour:
- Reset (async, immediate): all registers 0, all busy bits 0, pending_cnt 0, wr_conflict 0. While reset is high, rd_data is 0, rd_busy is 0, iss_stall is 0.
- Register 0 reads 0 always; writes to address 0 are ignored; address 0 is never marked busy.
- Writes take effect at the rising edge.
- Same address written by A and B in the same cycle:
  - A's data is stored (younger instruction).
  - The busy bit is still cleared by B.
  - wr_conflict = 1 for the following cycle only.
- Read port i, combinational, in priority order:
  1. rd_en=0 → 0.
  2. addr=0 → 0.
  3. wa_en && wa_addr==addr → wa_data.
  4. wb_en && wb_addr==addr → wb_data.
  5. Otherwise the stored value.
- rd_busy[i] = rd_en && addr!=0 && busy[addr] && !(wb_en && wb_addr==addr), i.e. an arriving load clears the hazard in the same cycle.
- iss_stall = iss_valid && iss_addr!=0 && busy[iss_addr] && !(wb_en && wb_addr==iss_addr).
  - A stalled issue does not change the scoreboard.
  - The issuer must hold iss_valid/iss_addr until iss_stall=0.
- Scoreboard update at each edge:
  - Set busy[iss_addr] if iss_valid && !iss_stall && iss_addr!=0.
  - Clear busy[wb_addr] if wb_en.
  - Set and clear on the same address in the same cycle → ends set (new load owns it).
- pending_cnt is registered, equal to the popcount of busy after the edge, updated incrementally:
  - +1 on set, -1 on clear, net 0 on the same-address set+clear.
  - Clearing a non-busy register does not decrement; count never underflows.
- wb_en to a non-busy register is legal: it writes data and leaves the scoreboard unchanged.
- dbg_data is the stored value of register DBG_IDX, with no bypass.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined: the busy scoreboard, rd_busy, iss_stall and pending_cnt behave as above.
- Undefined:
  - No busy storage is synthesised.
  - rd_busy, iss_stall and pending_cnt are tied to 0.
  - iss_valid and iss_addr are ignored.
  - Data path and wr_conflict are unchanged.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - ZERO_REG = 0;
  - the DBG_IDX default;
  - a function for the packed-slice index.
- One sub-module, regfile_scoreboard: busy vector, set/clear arbitration, pending_cnt, iss_stall. It is instantiated only under REGFILE_SCOREBOARD_EN.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, set busy r7, assert reset between edges → rd_data 0, pending_cnt 0, r5 reads 0 after release.
- Bypass priority: wa r3=0x11, wb r3=0x22, same cycle, read r3 → 0x11 combinational; next cycle stored 0x11; wr_conflict=1 for exactly one cycle.
- Scoreboard:
  - Issue load r9, then read r9 → rd_busy=1, pending_cnt=1.
  - Re-issue r9 → iss_stall=1.
  - wb r9=0x55 → rd_busy=0 and rd_data=0x55 in that cycle; pending_cnt=0 after the edge.
- Same-cycle set/clear: busy r4; issue r4 while wb r4 → busy r4 remains 1, pending_cnt stays 1, iss_stall=0.
- Zero register: wa r0=0xFFFFFFFF, issue r0 → r0 reads 0, rd_busy 0, pending_cnt 0; stray wb to non-busy r6 leaves pending_cnt unchanged.
- NUM_RD=4 build: four ports reading r1..r4 after writes 1..4 → each port returns its value; rd_en=0 port returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   ZERO_REG                : hard-wired zero register index
//   DBG_IDX_DEF             : default register exported on dbg_data
//   slice_lo()              : low bit of lane idx inside a packed lane bus
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int ZERO_REG    = 0;
  localparam int DBG_IDX_DEF = 28;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking outstanding load
// destinations. Only instantiated when REGFILE_SCOREBOARD_EN is defined.
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//   iss_valid, iss_addr     : load issue request (destination to mark busy)
//   wb_en, wb_addr          : load writeback (clears busy)
//   rd_en, rd_addr          : packed read-port enables/addresses
//   rd_busy                 : per-port hazard flag
//   iss_stall               : issue refused (WAW on a still-busy register)
//   pending_cnt             : registered popcount of the busy vector
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     iss_stall,
  output logic [ADDR_W:0]          pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             set_en;
  logic             clr_en;

  // A writeback landing on the same register this cycle resolves the hazard,
  // so neither the stall nor the read-side busy flag fires for it.
  assign iss_stall = !reset && iss_valid && (iss_addr != ZERO_ADDR) &&
                     busy[iss_addr] && !(wb_en && (wb_addr == iss_addr));

  assign set_en = iss_valid && !iss_stall && (iss_addr != ZERO_ADDR);
  // Only a clear of a register that is actually busy moves the count.
  assign clr_en = wb_en && busy[wb_addr];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign rd_busy[i] = !reset && rd_en[i] && (a != ZERO_ADDR) && busy[a] &&
                        !(wb_en && (wb_addr == a));
  end

  // Set is applied after clear so a same-address set+clear leaves the bit
  // set: the newly issued load owns the register.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)  busy_nxt[wb_addr]  = 1'b0;
    if (set_en) busy_nxt[iss_addr] = 1'b1;
  end

  // set_en can only coincide with an already-busy target when wb clears it
  // in the same cycle, so +set -clr gives the exact popcount change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= pending_cnt + (ADDR_W+1)'(set_en) - (ADDR_W+1)'(clr_en);
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with two write ports (A = ALU
// writeback, B = load writeback), combinational reads with write-to-read
// bypass, and an optional busy scoreboard for load destinations.
// Build option: define REGFILE_SCOREBOARD_EN to include the scoreboard;
// without it rd_busy, iss_stall and pending_cnt are tied to 0 and the
// issue inputs are ignored.
// Ports:
//   clock, reset                 : rising-edge clock, async active-high reset
//   rd_en, rd_addr, rd_data      : NUM_RD packed read ports
//   rd_busy                      : per-port outstanding-load flag
//   wa_en, wa_addr, wa_data      : write port A (wins on address collision)
//   wb_en, wb_addr, wb_data      : write port B (also clears busy)
//   iss_valid, iss_addr          : load issue, marks destination busy
//   iss_stall                    : issue refused on WAW with a busy register
//   pending_cnt                  : number of busy registers
//   wr_conflict                  : one-cycle pulse after A/B same-address write
//   dbg_data                     : stored value of register DBG_IDX
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int DBG_IDX = DBG_IDX_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  output logic [ADDR_W:0]          pending_cnt,
  output logic                     wr_conflict,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_conflict_p1;

  // Stage p0 -> p1: register writes and collision detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      wr_conflict_p1 <= 1'b0;
    end else begin
      // A is written last so it overrides B on a shared address.
      if (wb_en && (wb_addr != ZERO_ADDR)) regs[wb_addr] <= wb_data;
      if (wa_en && (wa_addr != ZERO_ADDR)) regs[wa_addr] <= wa_data;
      wr_conflict_p1 <= wa_en && wb_en && (wa_addr == wb_addr) &&
                        (wa_addr != ZERO_ADDR);
    end
  end

  assign wr_conflict = wr_conflict_p1;
  assign dbg_data    = regs[DBG_IDX];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] word;
    assign a = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

    // Reset is folded in so a live write bypass cannot leak through while
    // the file is being cleared.
    always_comb begin
      word = '0;
      if (reset || !rd_en[i] || (a == ZERO_ADDR)) word = '0;
      else if (wa_en && (wa_addr == a))           word = wa_data;
      else if (wb_en && (wb_addr == a))           word = wb_data;
      else                                        word = regs[a];
    end

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = word;
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .iss_stall   (iss_stall),
    .pending_cnt (pending_cnt)
  );
`else
  logic unused_iss;
  assign unused_iss  = ^{iss_valid, iss_addr};
  assign rd_busy     = '0;
  assign iss_stall   = 1'b0;
  assign pending_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb built with four read ports. Scoreboard
// expectations follow REGFILE_SCOREBOARD_EN: when it is undefined the busy,
// stall and count outputs are expected to stay at 0.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wa_en, wb_en, iss_valid;
  logic [AW-1:0]    wa_addr, wb_addr, iss_addr;
  logic [DW-1:0]    wa_data, wb_data;
  logic             iss_stall, wr_conflict;
  logic [AW:0]      pending_cnt;
  logic [DW-1:0]    dbg_data;

  int errors = 0;
  int checks = 0;

  regfile_mp_sb #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .DBG_IDX (28)
  ) dut (
    .clock (clock), .reset (reset),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
    .wa_en (wa_en), .wa_addr (wa_addr), .wa_data (wa_data),
    .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
    .iss_valid (iss_valid), .iss_addr (iss_addr), .iss_stall (iss_stall),
    .pending_cnt (pending_cnt), .wr_conflict (wr_conflict), .dbg_data (dbg_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_valid = 0;
    wa_addr = '0; wb_addr = '0; iss_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rdw(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic test_reset();
    reset = 1; idle(); rd_en = '0; rd_addr = '0;
    set_rd(0, 1, 5'd1);
    wa_en = 1; wa_addr = 5'd1; wa_data = 32'hAAAA_5555;
    iss_valid = 1; iss_addr = 5'd2;
    tick(); tick();
    checks++; if (rdw(0) !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h want=%h", rdw(0), 32'h0); end
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL reset_pending got=%0d want=0", pending_cnt); end
    checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_wr_conflict got=%b want=0", wr_conflict); end
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL reset_iss_stall got=%b want=0", iss_stall); end
    idle();
    reset = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    wa_en = 1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
    iss_valid = 1; iss_addr = 5'd7;
    tick();
    idle();
    set_rd(0, 1, 5'd5); set_rd(1, 1, 5'd7);
    #1;
    checks++; if (rdw(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_r5_before got=%h want=%h", rdw(0), 32'hDEAD_BEEF); end
    checks++; if (pending_cnt !== (AW+1)'(SB_ON)) begin errors++; $display("FAIL mid_pending_before got=%0d want=%0d", pending_cnt, SB_ON); end
    checks++; if (rd_busy[1] !== SB_ON) begin errors++; $display("FAIL mid_r7_busy got=%b want=%b", rd_busy[1], SB_ON); end
    #1 reset = 1;
    #1;
    checks++; if (rdw(0) !== 32'h0) begin errors++; $display("FAIL mid_rd_data_in_reset got=%h want=0", rdw(0)); end
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL mid_pending_in_reset got=%0d want=0", pending_cnt); end
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL mid_busy_in_reset got=%b want=0", rd_busy[1]); end
    #2 reset = 0;
    #1;
    checks++; if (rdw(0) !== 32'h0) begin errors++; $display("FAIL mid_r5_after got=%h want=0", rdw(0)); end
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL mid_r7_after got=%b want=0", rd_busy[1]); end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    set_rd(0, 1, 5'd3);
    wa_en = 1; wa_addr = 5'd3; wa_data = 32'h11;
    wb_en = 1; wb_addr = 5'd3; wb_data = 32'h22;
    #1;
    checks++; if (rdw(0) !== 32'h11) begin errors++; $display("FAIL bypass_a_over_b got=%h want=%h", rdw(0), 32'h11); end
    tick();
    idle();
    #1;
    checks++; if (rdw(0) !== 32'h11) begin errors++; $display("FAIL bypass_stored got=%h want=%h", rdw(0), 32'h11); end
    checks++; if (wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse got=%b want=1", wr_conflict); end
    wb_en = 1; wb_addr = 5'd3; wb_data = 32'h33;
    #1;
    checks++; if (rdw(0) !== 32'h33) begin errors++; $display("FAIL bypass_b_only got=%h want=%h", rdw(0), 32'h33); end
    tick();
    idle();
    checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle got=%b want=0", wr_conflict); end
    checks++; if (rdw(0) !== 32'h33) begin errors++; $display("FAIL b_stored got=%h want=%h", rdw(0), 32'h33); end
    // A and B both targeting r0 is not a conflict.
    wa_en = 1; wb_en = 1; wa_addr = 5'd0; wb_addr = 5'd0;
    tick();
    idle();
    checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_r0 got=%b want=0", wr_conflict); end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(0, 1, 5'd9);
    iss_valid = 1; iss_addr = 5'd9;
    tick();
    idle();
    #1;
    checks++; if (rd_busy[0] !== SB_ON) begin errors++; $display("FAIL sb_r9_busy got=%b want=%b", rd_busy[0], SB_ON); end
    checks++; if (pending_cnt !== (AW+1)'(SB_ON)) begin errors++; $display("FAIL sb_pending_1 got=%0d want=%0d", pending_cnt, SB_ON); end
    iss_valid = 1; iss_addr = 5'd9;
    #1;
    checks++; if (iss_stall !== SB_ON) begin errors++; $display("FAIL sb_waw_stall got=%b want=%b", iss_stall, SB_ON); end
    tick();
    idle();
    checks++; if (pending_cnt !== (AW+1)'(SB_ON)) begin errors++; $display("FAIL sb_stall_no_change got=%0d want=%0d", pending_cnt, SB_ON); end
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'h55;
    #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_clears_hazard got=%b want=0", rd_busy[0]); end
    checks++; if (rdw(0) !== 32'h55) begin errors++; $display("FAIL sb_wb_bypass got=%h want=%h", rdw(0), 32'h55); end
    tick();
    idle();
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL sb_pending_0 got=%0d want=0", pending_cnt); end
  endtask

  task automatic test_same_cycle_set_clear();
    idle();
    set_rd(1, 1, 5'd4);
    iss_valid = 1; iss_addr = 5'd4;
    tick();
    iss_valid = 1; iss_addr = 5'd4;
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'h44;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL sc_no_stall got=%b want=0", iss_stall); end
    tick();
    idle();
    #1;
    checks++; if (pending_cnt !== (AW+1)'(SB_ON)) begin errors++; $display("FAIL sc_pending_held got=%0d want=%0d", pending_cnt, SB_ON); end
    checks++; if (rd_busy[1] !== SB_ON) begin errors++; $display("FAIL sc_r4_still_busy got=%b want=%b", rd_busy[1], SB_ON); end
    // Second load on another register, then retire both.
    iss_valid = 1; iss_addr = 5'd10;
    tick();
    idle();
    checks++; if (pending_cnt !== (AW+1)'(2 * SB_ON)) begin errors++; $display("FAIL sc_pending_2 got=%0d want=%0d", pending_cnt, 2 * SB_ON); end
    wb_en = 1; wb_addr = 5'd4;
    tick();
    wb_addr = 5'd10;
    tick();
    idle();
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL sc_pending_drained got=%0d want=0", pending_cnt); end
  endtask

  task automatic test_zero_reg();
    idle();
    set_rd(2, 1, 5'd0);
    wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    iss_valid = 1; iss_addr = 5'd0;
    #1;
    checks++; if (rdw(2) !== 32'h0) begin errors++; $display("FAIL zr_no_bypass got=%h want=0", rdw(2)); end
    tick();
    idle();
    checks++; if (rdw(2) !== 32'h0) begin errors++; $display("FAIL zr_stored got=%h want=0", rdw(2)); end
    checks++; if (rd_busy[2] !== 1'b0) begin errors++; $display("FAIL zr_busy got=%b want=0", rd_busy[2]); end
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL zr_pending got=%0d want=0", pending_cnt); end
    set_rd(2, 1, 5'd6);
    wb_en = 1; wb_addr = 5'd6; wb_data = 32'h66;
    tick();
    idle();
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL stray_wb_pending got=%0d want=0", pending_cnt); end
    checks++; if (rdw(2) !== 32'h66) begin errors++; $display("FAIL stray_wb_data got=%h want=%h", rdw(2), 32'h66); end
  endtask

  task automatic test_multi_port();
    idle();
    wa_en = 1; wa_addr = 5'd1; wa_data = 32'd1;
    wb_en = 1; wb_addr = 5'd2; wb_data = 32'd2;
    tick();
    wa_addr = 5'd3; wa_data = 32'd3;
    wb_addr = 5'd4; wb_data = 32'd4;
    tick();
    idle();
    for (int p = 0; p < NR; p++) set_rd(p, 1, 5'(p + 1));
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rdw(p) !== 32'(p + 1)) begin errors++; $display("FAIL mp_port%0d got=%h want=%h", p, rdw(p), 32'(p + 1)); end
    end
    rd_en[2] = 1'b0;
    #1;
    checks++; if (rdw(2) !== 32'h0) begin errors++; $display("FAIL mp_disabled_port got=%h want=0", rdw(2)); end
    checks++; if (rdw(3) !== 32'd4) begin errors++; $display("FAIL mp_port3_unaffected got=%h want=%h", rdw(3), 32'd4); end
  endtask

  task automatic test_dbg();
    idle();
    wa_en = 1; wa_addr = 5'd28; wa_data = 32'hCAFE_F00D;
    #1;
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL dbg_no_bypass got=%h want=0", dbg_data); end
    tick();
    idle();
    checks++; if (dbg_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL dbg_stored got=%h want=%h", dbg_data, 32'hCAFE_F00D); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_bypass();
    test_scoreboard();
    test_same_cycle_set_clear();
    test_zero_reg();
    test_multi_port();
    test_dbg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
